pong_engine_param: RTL and testbench

// Parametrised successor to the single-screen pong graph/physics block. It owns two

---
 rtl/pong_engine_param.sv | 208 ++++++++++++++++++++
 tb/tb_pong_engine_param.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_engine_param.sv
// pong_engine_param: two-paddle pong physics with serve/score FSM and object renderer.
// Physics state advances once per frame on the tick pixel; rendering is combinational.
module pong_engine_param #(
  parameter int unsigned MAX_X     = 640,
  parameter int unsigned MAX_Y     = 480,
  parameter int unsigned BAR_L_X   = 32,
  parameter int unsigned BAR_R_X   = 600,
  parameter int unsigned BAR_W     = 4,
  parameter int unsigned BAR_H     = 72,
  parameter int unsigned BAR_V     = 4,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned V_INIT    = 2,
  parameter int unsigned V_MAX     = 6,
  parameter int unsigned HITS_STEP = 4,
  parameter int unsigned HOLD_FR   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       serve,
  output logic       graph_on,
  output logic [2:0] graph_rgb,
  output logic       hit,
  output logic       miss_l,
  output logic       miss_r
);
  localparam int unsigned PW     = 10;
  localparam int unsigned SW     = 11;
  localparam int unsigned SPD_W  = $clog2(V_MAX + 1);
  localparam int unsigned HC_W   = $clog2(HITS_STEP + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FR + 1);

  localparam logic [PW-1:0]    BAR_Y0     = PW'((MAX_Y - BAR_H) / 2);
  localparam logic [PW-1:0]    BAR_Y_MAX  = PW'(MAX_Y - BAR_H);
  localparam logic [PW-1:0]    BALL_X0    = PW'((MAX_X - BALL_SIZE) / 2);
  localparam logic [PW-1:0]    BALL_Y0    = PW'((MAX_Y - BALL_SIZE) / 2);
  localparam logic [SW-1:0]    BALL_Y_MAX = SW'(MAX_Y - BALL_SIZE);
  localparam logic [SPD_W-1:0] SPD_INIT   = SPD_W'(V_INIT);
  localparam logic [SPD_W-1:0] SPD_MAX    = SPD_W'(V_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     bar_l_y, bar_l_y_nxt, bar_r_y, bar_r_y_nxt;
  logic [PW-1:0]     ball_x, ball_x_nxt, ball_y, ball_y_nxt;
  logic              dir_x, dir_x_nxt;          // 1 = moving right
  logic              dir_y, dir_y_nxt;          // 1 = moving down
  logic              miss_side_r, miss_side_r_nxt;
  logic [SPD_W-1:0]  spd, spd_nxt;
  logic [HC_W-1:0]   hit_cnt, hit_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              hit_nxt, miss_l_nxt, miss_r_nxt;

  logic              tick;
  logic [SW-1:0]     bx, by, sp, px, py;
  logic              row_l, row_r, hit_l, hit_r, lost_l, lost_r, miss_now, dy;
  logic              ball_on, bar_l_on, bar_r_on;

  // Paddle step for one frame, clamped to the screen; both or neither button holds.
  function automatic logic [PW-1:0] bar_move(input logic [PW-1:0] y, input logic [1:0] b);
    logic [PW-1:0] r;
    r = y;
    if (b == 2'b10)
      r = (y >= PW'(BAR_V)) ? y - PW'(BAR_V) : '0;
    else if (b == 2'b01)
      r = (SW'(y) + SW'(BAR_V) >= SW'(BAR_Y_MAX)) ? BAR_Y_MAX : y + PW'(BAR_V);
    return r;
  endfunction

  // Frame tick and 11-bit collision/miss terms (no wrap-around in the sums).
  assign tick     = (pix_x == PW'(0)) && (pix_y == PW'(MAX_Y + 1));
  assign bx       = SW'(ball_x);
  assign by       = SW'(ball_y);
  assign sp       = SW'(spd);
  assign row_l    = (by < SW'(bar_l_y) + SW'(BAR_H)) && (by + SW'(BALL_SIZE) > SW'(bar_l_y));
  assign row_r    = (by < SW'(bar_r_y) + SW'(BAR_H)) && (by + SW'(BALL_SIZE) > SW'(bar_r_y));
  assign hit_r    = dir_x && (bx + SW'(BALL_SIZE) + sp >= SW'(BAR_R_X)) &&
                    (bx < SW'(BAR_R_X)) && row_r;
  assign hit_l    = !dir_x && (bx <= SW'(BAR_L_X + BAR_W - 1) + sp) &&
                    (bx + SW'(BALL_SIZE) > SW'(BAR_L_X + BAR_W)) && row_l;
  assign lost_l   = (bx <= sp);
  assign lost_r   = (bx + SW'(BALL_SIZE) + sp >= SW'(MAX_X));
  assign miss_now = !(hit_l || hit_r) && (lost_l || lost_r);

  // Next-state and per-frame physics update.
  always_comb begin
    state_nxt       = state;
    bar_l_y_nxt     = bar_l_y;
    bar_r_y_nxt     = bar_r_y;
    ball_x_nxt      = ball_x;
    ball_y_nxt      = ball_y;
    dir_x_nxt       = dir_x;
    dir_y_nxt       = dir_y;
    miss_side_r_nxt = miss_side_r;
    spd_nxt         = spd;
    hit_cnt_nxt     = hit_cnt;
    hold_cnt_nxt    = hold_cnt;
    hit_nxt         = 1'b0;
    miss_l_nxt      = 1'b0;
    miss_r_nxt      = 1'b0;
    dy              = dir_y;
    if (tick) begin
      bar_l_y_nxt = bar_move(bar_l_y, btn1);
      bar_r_y_nxt = bar_move(bar_r_y, btn2);
      unique case (state)
        IDLE: begin
          if (serve) begin
            state_nxt   = PLAY;
            spd_nxt     = SPD_INIT;
            hit_cnt_nxt = '0;
          end
        end
        PLAY: begin
          if (hit_l || hit_r) begin
            hit_nxt   = 1'b1;
            dir_x_nxt = hit_l;
            if (hit_cnt + HC_W'(1) == HC_W'(HITS_STEP)) begin
              hit_cnt_nxt = '0;
              spd_nxt     = (spd >= SPD_MAX) ? SPD_MAX : spd + SPD_W'(1);
            end else begin
              hit_cnt_nxt = hit_cnt + HC_W'(1);
            end
          end else if (miss_now) begin
            miss_l_nxt      = lost_l;
            miss_r_nxt      = lost_r;
            miss_side_r_nxt = lost_r;
            state_nxt       = HOLD;
            hold_cnt_nxt    = '0;
          end
          if (by <= sp) dy = 1'b1;
          if (by + SW'(BALL_SIZE) + sp >= SW'(MAX_Y)) dy = 1'b0;
          dir_y_nxt = dy;
          if (!miss_now) begin
            ball_x_nxt = dir_x_nxt ? PW'(bx + sp) : ((bx >= sp) ? PW'(bx - sp) : '0);
            if (dy)
              ball_y_nxt = (by + sp >= BALL_Y_MAX) ? PW'(BALL_Y_MAX) : PW'(by + sp);
            else
              ball_y_nxt = (by >= sp) ? PW'(by - sp) : '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_FR - 1)) begin
            hold_cnt_nxt = '0;
            ball_x_nxt   = BALL_X0;
            ball_y_nxt   = BALL_Y0;
            dir_x_nxt    = miss_side_r;
            spd_nxt      = SPD_INIT;
            state_nxt    = IDLE;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bar_l_y     <= BAR_Y0;
      bar_r_y     <= BAR_Y0;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      miss_side_r <= 1'b0;
      spd         <= SPD_INIT;
      hit_cnt     <= '0;
      hold_cnt    <= '0;
      hit         <= 1'b0;
      miss_l      <= 1'b0;
      miss_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      bar_l_y     <= bar_l_y_nxt;
      bar_r_y     <= bar_r_y_nxt;
      ball_x      <= ball_x_nxt;
      ball_y      <= ball_y_nxt;
      dir_x       <= dir_x_nxt;
      dir_y       <= dir_y_nxt;
      miss_side_r <= miss_side_r_nxt;
      spd         <= spd_nxt;
      hit_cnt     <= hit_cnt_nxt;
      hold_cnt    <= hold_cnt_nxt;
      hit         <= hit_nxt;
      miss_l      <= miss_l_nxt;
      miss_r      <= miss_r_nxt;
    end
  end

  // Object coverage for the current pixel; ball has priority over paddles.
  assign px       = SW'(pix_x);
  assign py       = SW'(pix_y);
  assign ball_on  = (px >= bx) && (px < bx + SW'(BALL_SIZE)) &&
                    (py >= by) && (py < by + SW'(BALL_SIZE));
  assign bar_l_on = (px >= SW'(BAR_L_X)) && (px < SW'(BAR_L_X + BAR_W)) &&
                    (py >= SW'(bar_l_y)) && (py < SW'(bar_l_y) + SW'(BAR_H));
  assign bar_r_on = (px >= SW'(BAR_R_X)) && (px < SW'(BAR_R_X + BAR_W)) &&
                    (py >= SW'(bar_r_y)) && (py < SW'(bar_r_y) + SW'(BAR_H));
  assign graph_on  = ball_on || bar_l_on || bar_r_on;
  assign graph_rgb = ball_on ? 3'b100 : ((bar_l_on || bar_r_on) ? 3'b010 : 3'b000);

endmodule

// File: tb/tb_pong_engine_param.sv
// tb_pong_engine_param: randomized frames against a frame-level reference model of the game.
module tb_pong_engine_param;
  localparam int MAX_X = 640, MAX_Y = 480, BAR_L_X = 32, BAR_R_X = 600, BAR_W = 4;
  localparam int BAR_H = 72, BAR_V = 4, BALL = 8, V_INIT = 2, V_MAX = 6;
  localparam int HITS_STEP = 4, HOLD_FR = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic [1:0] btn1, btn2;
  logic       serve;
  logic       graph_on;
  logic [2:0] graph_rgb;
  logic       hit, miss_l, miss_r;

  pong_engine_param dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .btn1(btn1), .btn2(btn2),
    .serve(serve), .graph_on(graph_on), .graph_rgb(graph_rgb), .hit(hit),
    .miss_l(miss_l), .miss_r(miss_r)
  );

  always #5 clk = ~clk;

  int n_vec, n_err;

  // Reference model: positions as plain ints, directions as +1/-1.
  int   m_bl, m_br, m_bx, m_by, m_dx, m_dy, m_spd, m_hits, m_hold, m_side, m_mode;
  logic m_hit, m_ml, m_mr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int pad_next(input int y, input logic [1:0] b);
    if (b == 2'b10) return clampi(y - BAR_V, 0, MAX_Y - BAR_H);
    if (b == 2'b01) return clampi(y + BAR_V, 0, MAX_Y - BAR_H);
    return y;
  endfunction

  function automatic bit rows(input int y, input int bar);
    return (y < bar + BAR_H) && (y + BALL > bar);
  endfunction

  task automatic model_reset();
    m_bl = (MAX_Y - BAR_H) / 2;  m_br = (MAX_Y - BAR_H) / 2;
    m_bx = (MAX_X - BALL) / 2;   m_by = (MAX_Y - BALL) / 2;
    m_dx = 1; m_dy = 1; m_spd = V_INIT; m_hits = 0; m_hold = 0; m_side = 1;
    m_mode = M_IDLE; m_hit = 1'b0; m_ml = 1'b0; m_mr = 1'b0;
  endtask

  task automatic model_tick();
    int s, obl, obr;
    bit h, ml, mr;
    obl = m_bl; obr = m_br;
    m_bl = pad_next(m_bl, btn1);
    m_br = pad_next(m_br, btn2);
    m_hit = 1'b0; m_ml = 1'b0; m_mr = 1'b0;
    case (m_mode)
      M_IDLE: if (serve) begin m_mode = M_PLAY; m_spd = V_INIT; m_hits = 0; end
      M_PLAY: begin
        s = m_spd; h = 0; ml = 0; mr = 0;
        if (m_dx > 0 && m_bx + BALL + s >= BAR_R_X && m_bx < BAR_R_X && rows(m_by, obr)) begin
          h = 1; m_dx = -1;
        end else if (m_dx < 0 && m_bx <= BAR_L_X + BAR_W - 1 + s &&
                     m_bx + BALL > BAR_L_X + BAR_W && rows(m_by, obl)) begin
          h = 1; m_dx = 1;
        end
        if (h) begin
          m_hit = 1'b1; m_hits++;
          if (m_hits == HITS_STEP) begin m_hits = 0; if (m_spd < V_MAX) m_spd++; end
        end else begin
          ml = (m_bx <= s);
          mr = (m_bx + BALL >= MAX_X - s);
        end
        if (m_by <= s) m_dy = 1;
        if (m_by + BALL >= MAX_Y - s) m_dy = -1;
        if (ml || mr) begin
          m_ml = ml; m_mr = mr; m_mode = M_HOLD; m_hold = 0; m_side = mr ? 1 : -1;
        end else begin
          m_bx = m_bx + m_dx * s;
          m_by = clampi(m_by + m_dy * s, 0, MAX_Y - BALL);
        end
      end
      default: begin
        if (m_hold == HOLD_FR - 1) begin
          m_hold = 0; m_bx = (MAX_X - BALL) / 2; m_by = (MAX_Y - BALL) / 2;
          m_dx = m_side; m_spd = V_INIT; m_mode = M_IDLE;
        end else m_hold++;
      end
    endcase
  endtask

  function automatic logic [2:0] model_rgb(input int x, input int y);
    if (x >= m_bx && x < m_bx + BALL && y >= m_by && y < m_by + BALL) return 3'b100;
    if (x >= BAR_L_X && x < BAR_L_X + BAR_W && y >= m_bl && y < m_bl + BAR_H) return 3'b010;
    if (x >= BAR_R_X && x < BAR_R_X + BAR_W && y >= m_br && y < m_br + BAR_H) return 3'b010;
    return 3'b000;
  endfunction

  // Ball row when it next reaches the paddle on side dir (for steering only).
  function automatic int predict_y(input int dir);
    int x, y, dy, s;
    x = m_bx; y = m_by; dy = m_dy; s = m_spd;
    for (int k = 0; k < 400; k++) begin
      if (dir > 0 && x + BALL + s >= BAR_R_X) break;
      if (dir < 0 && x <= BAR_L_X + BAR_W - 1 + s) break;
      if (y <= s) dy = 1;
      if (y + BALL >= MAX_Y - s) dy = -1;
      x = x + dir * s;
      y = clampi(y + dy * s, 0, MAX_Y - BALL);
    end
    return y;
  endfunction

  function automatic logic [1:0] steer(input int y, input int t);
    if (y < t - 2) return 2'b01;
    if (y > t + 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic track(input bit right_too);
    int tl, tr;
    tl = (m_mode == M_PLAY && m_dx < 0) ? predict_y(-1) + BALL / 2 - BAR_H / 2 : (MAX_Y - BAR_H) / 2;
    tr = (m_mode == M_PLAY && m_dx > 0) ? predict_y(1) + BALL / 2 - BAR_H / 2 : (MAX_Y - BAR_H) / 2;
    btn1 = steer(m_bl, tl);
    if (right_too) btn2 = steer(m_br, tr);
    if ($urandom_range(0, 15) == 0) btn1 = 2'($urandom);
  endtask

  task automatic probe(input string tag, input int x, input int y);
    int cx, cy;
    logic [2:0] e;
    cx = clampi(x, 0, MAX_X - 1);
    cy = clampi(y, 0, MAX_Y - 1);
    pix_x = 10'(cx); pix_y = 10'(cy);
    @(negedge clk);
    e = model_rgb(cx, cy);
    check_eq({tag, "_rgb"}, 32'(graph_rgb), 32'(e));
    check_eq({tag, "_on"}, 32'(graph_on), 32'(e != 3'b000));
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_ball_x"}, 32'(dut.ball_x), m_bx);
    check_eq({tag, "_ball_y"}, 32'(dut.ball_y), m_by);
    check_eq({tag, "_bar_l"}, 32'(dut.bar_l_y), m_bl);
    check_eq({tag, "_bar_r"}, 32'(dut.bar_r_y), m_br);
    check_eq({tag, "_spd"}, 32'(dut.spd), m_spd);
  endtask

  task automatic probe_all();
    probe("ball_tl", m_bx, m_by);
    probe("ball_br", m_bx + BALL - 1, m_by + BALL - 1);
    probe("ball_lo", m_bx - 1, m_by);
    probe("ball_ro", m_bx + BALL, m_by + BALL - 1);
    probe("ball_bo", m_bx + 3, m_by + BALL);
    probe("barl_tl", BAR_L_X, m_bl);
    probe("barl_ro", BAR_L_X + BAR_W, m_bl + BAR_H - 1);
    probe("barr_br", BAR_R_X + BAR_W - 1, m_br + BAR_H - 1);
    probe("barr_bo", BAR_R_X, m_br + BAR_H);
    probe("barr_lo", BAR_R_X - 1, m_br);
  endtask

  // One video frame: tick edge, pulse check, pulse-fall check, state and pixel checks.
  task automatic frame();
    pix_x = 10'd0; pix_y = 10'(MAX_Y + 1);
    @(posedge clk); #1;
    model_tick();
    pix_x = 10'd1; pix_y = 10'd0;
    check_eq("hit", 32'(hit), 32'(m_hit));
    check_eq("miss_l", 32'(miss_l), 32'(m_ml));
    check_eq("miss_r", 32'(miss_r), 32'(m_mr));
    @(posedge clk); #1;
    check_eq("hit_fall", 32'(hit), 32'd0);
    check_eq("miss_l_fall", 32'(miss_l), 32'd0);
    check_eq("miss_r_fall", 32'(miss_r), 32'd0);
    check_state("frm");
    probe_all();
  endtask

  // Reset asserted on a tick pixel so a pending update must be discarded.
  task automatic do_reset();
    rst_n = 1'b0; pix_x = 10'd0; pix_y = 10'(MAX_Y + 1);
    @(posedge clk); #1;
    rst_n = 1'b1; pix_x = 10'd1; pix_y = 10'd0;
    model_reset();
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_miss_l", 32'(miss_l), 32'd0);
    check_eq("rst_miss_r", 32'(miss_r), 32'd0);
    check_state("rst");
    probe_all();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b1; pix_x = 10'd1; pix_y = 10'd0; btn1 = 2'b00; btn2 = 2'b00; serve = 1'b0;
    do_reset();
    check_eq("rst_ball_x_abs", 32'(dut.ball_x), 32'd316);
    check_eq("rst_ball_y_abs", 32'(dut.ball_y), 32'd236);
    check_eq("rst_bar_abs", 32'(dut.bar_l_y), 32'd204);

    // Left paddle up against the top, then both buttons pressed.
    btn1 = 2'b10; btn2 = 2'($urandom);
    repeat (60) frame();
    check_eq("bar_l_top", 32'(dut.bar_l_y), 32'd0);
    btn1 = 2'b01; btn2 = 2'b00;
    repeat (10) frame();
    btn1 = 2'b11;
    repeat (5) frame();
    check_eq("bar_l_both", 32'(dut.bar_l_y), 32'd40);

    // Serve and first move.
    btn1 = 2'b00; serve = 1'b1;
    frame();
    serve = 1'b0;
    frame();
    check_eq("serve_x", 32'(dut.ball_x), 32'd318);
    check_eq("serve_y", 32'(dut.ball_y), 32'd238);

    // Long rally with paddles steered toward the ball so speed climbs to the ceiling.
    for (int f = 0; f < 3200; f++) begin
      track(1'b1);
      serve = (m_mode == M_IDLE) && ($urandom_range(0, 3) == 0);
      frame();
    end

    // Right paddle parked at the top: low balls get past it.
    do_reset();
    for (int f = 0; f < 500; f++) begin
      track(1'b0);
      btn2 = 2'b10;
      serve = (m_mode == M_IDLE) && ($urandom_range(0, 3) == 0);
      frame();
    end

    // Unconstrained random play.
    for (int f = 0; f < 400; f++) begin
      btn1 = 2'($urandom); btn2 = 2'($urandom); serve = 1'($urandom);
      frame();
    end

    // Reset in the middle of a rally.
    do_reset();
    btn1 = 2'b00; btn2 = 2'b00; serve = 1'b1;
    frame();
    serve = 1'b0;
    repeat (10) frame();
    do_reset();
    repeat (3) frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
